// File: rtl/mat2x2_pkg.sv
// Shared widths, opcodes and sequencer state type for the 2x2 matrix ALU wrapper.
package mat2x2_pkg;

  localparam int ELEM_W = 8;
  localparam int RES_W  = 16;
  localparam int N_ELEM = 8;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/mat2x2_alu_sequencer.sv
// Byte-stream operand collector and word-stream result emitter around a
// combinational 2x2 matrix ALU.
//
//   state | meaning
//   LOAD  | accepting a00..b11, one element per input handshake
//   WAIT  | operands held stable, settle counter running down
//   OUT   | four captured result words streamed out, idx 0..3
module mat2x2_alu_sequencer
  import mat2x2_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ELEM_W-1:0]      in_data,
  input  logic [1:0]             in_op,
  output logic [4*ELEM_W-1:0]    alu_a,
  output logic [4*ELEM_W-1:0]    alu_b,
  output logic [1:0]             alu_op,
  input  logic [4*RES_W-1:0]     alu_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RES_W-1:0]       out_data,
  output logic [1:0]             out_idx,
  output logic                   out_last,
  output logic                   out_err,
  output logic                   busy
);

  state_t                 state, state_nxt;
  logic [2:0]             elem_cnt;
  logic [3:0]             settle_cnt;
  logic [8*ELEM_W-1:0]    operands;
  logic [4*RES_W-1:0]     result;
  logic                   err_job;
  logic                   in_fire, out_fire, last_elem, settle_done;

  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign last_elem   = in_fire && (elem_cnt == 3'(N_ELEM - 1));
  assign settle_done = (state == WAIT) && (settle_cnt == 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (last_elem) state_nxt = WAIT;
      WAIT:    if (settle_done) state_nxt = OUT;
      OUT:     if (out_fire && out_idx == 2'd3) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Element counter wraps 7 -> 0 on the last handshake, ready for the next job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt <= '0;
      operands <= '0;
      alu_op   <= '0;
    end else if (in_fire) begin
      elem_cnt                         <= elem_cnt + 3'd1;
      operands[{elem_cnt, 3'b000} +: ELEM_W] <= in_data;
      if (elem_cnt == 3'd0) alu_op <= in_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 settle_cnt <= '0;
    else if (last_elem)                         settle_cnt <= 4'(SETTLE_CYCLES);
    else if (state == WAIT && settle_cnt != '0) settle_cnt <= settle_cnt - 4'd1;
  end

  // A reserved opcode yields zero results; whatever the ALU drives is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      err_job <= 1'b0;
    end else if (settle_done) begin
      result  <= (alu_op == OP_RSVD) ? '0 : alu_y;
      err_job <= (alu_op == OP_RSVD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        out_idx <= '0;
    else if (out_fire) out_idx <= out_idx + 2'd1;
  end

  assign alu_a     = operands[4*ELEM_W-1:0];
  assign alu_b     = operands[8*ELEM_W-1:4*ELEM_W];
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUT);
  assign out_data  = result[{out_idx, 4'b0000} +: RES_W];
  assign out_last  = out_valid && (out_idx == 2'd3);
  assign out_err   = out_valid && err_job;
  assign busy      = (state != LOAD) || (elem_cnt != 3'd0);

endmodule

// File: tb/tb_mat2x2_alu_sequencer.sv
// Self-checking bench: two sequencers (settle 2 and settle 1) with a behavioural
// 2x2 ALU stand-in, checked against a matrix-arithmetic reference model.
module tb_mat2x2_alu_sequencer;
  import mat2x2_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_op;
  int          sel;
  int          settle;
  int          n_checks = 0;
  int          n_fail = 0;

  logic        in_ready_0, out_valid_0, out_last_0, out_err_0, busy_0;
  logic        in_ready_1, out_valid_1, out_last_1, out_err_1, busy_1;
  logic [15:0] out_data_0, out_data_1;
  logic [1:0]  out_idx_0, out_idx_1, alu_op_0, alu_op_1;
  logic [31:0] alu_a_0, alu_a_1, alu_b_0, alu_b_1;
  logic [63:0] alu_y_0, alu_y_1;

  logic        in_ready, out_valid, out_last, out_err, busy;
  logic [15:0] out_data;
  logic [1:0]  out_idx, alu_op;
  logic [31:0] alu_a, alu_b;

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [7:0] a[4],
                                             input logic [7:0] b[4]);
    int y[4];
    y = '{0, 0, 0, 0};
    case (op)
      2'b00: for (int i = 0; i < 4; i++) y[i] = int'(a[i]) + int'(b[i]);
      2'b01: for (int i = 0; i < 4; i++) y[i] = int'(a[i]) - int'(b[i]);
      2'b10: begin
        y[0] = int'(a[0]) * int'(b[0]) + int'(a[1]) * int'(b[2]);
        y[1] = int'(a[0]) * int'(b[1]) + int'(a[1]) * int'(b[3]);
        y[2] = int'(a[2]) * int'(b[0]) + int'(a[3]) * int'(b[2]);
        y[3] = int'(a[2]) * int'(b[1]) + int'(a[3]) * int'(b[3]);
      end
      default: y = '{0, 0, 0, 0};
    endcase
    return {16'(y[3]), 16'(y[2]), 16'(y[1]), 16'(y[0])};
  endfunction

  // ALU stand-in; drives junk on the reserved opcode so it must be discarded.
  function automatic logic [63:0] alu_model(input logic [1:0] op, input logic [31:0] pa,
                                            input logic [31:0] pb);
    logic [7:0] a[4];
    logic [7:0] b[4];
    for (int i = 0; i < 4; i++) begin
      a[i] = pa[8*i +: 8];
      b[i] = pb[8*i +: 8];
    end
    if (op == 2'b11) return 64'hA5A5_5A5A_1234_FEDC;
    return ref_result(op, a, b);
  endfunction

  assign alu_y_0 = alu_model(alu_op_0, alu_a_0, alu_b_0);
  assign alu_y_1 = alu_model(alu_op_1, alu_a_1, alu_b_1);

  mat2x2_alu_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && sel == 0), .in_ready(in_ready_0), .in_data(in_data), .in_op(in_op),
    .alu_a(alu_a_0), .alu_b(alu_b_0), .alu_op(alu_op_0), .alu_y(alu_y_0),
    .out_valid(out_valid_0), .out_ready(out_ready && sel == 0), .out_data(out_data_0),
    .out_idx(out_idx_0), .out_last(out_last_0), .out_err(out_err_0), .busy(busy_0)
  );

  mat2x2_alu_sequencer #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && sel == 1), .in_ready(in_ready_1), .in_data(in_data), .in_op(in_op),
    .alu_a(alu_a_1), .alu_b(alu_b_1), .alu_op(alu_op_1), .alu_y(alu_y_1),
    .out_valid(out_valid_1), .out_ready(out_ready && sel == 1), .out_data(out_data_1),
    .out_idx(out_idx_1), .out_last(out_last_1), .out_err(out_err_1), .busy(busy_1)
  );

  assign in_ready  = (sel == 1) ? in_ready_1  : in_ready_0;
  assign out_valid = (sel == 1) ? out_valid_1 : out_valid_0;
  assign out_last  = (sel == 1) ? out_last_1  : out_last_0;
  assign out_err   = (sel == 1) ? out_err_1   : out_err_0;
  assign busy      = (sel == 1) ? busy_1      : busy_0;
  assign out_data  = (sel == 1) ? out_data_1  : out_data_0;
  assign out_idx   = (sel == 1) ? out_idx_1   : out_idx_0;
  assign alu_op    = (sel == 1) ? alu_op_1    : alu_op_0;
  assign alu_a     = (sel == 1) ? alu_a_1     : alu_a_0;
  assign alu_b     = (sel == 1) ? alu_b_1     : alu_b_0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s (sel=%0d): observed %0h expected %0h", tag, sel, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
  endtask

  task automatic send_elem(input logic [7:0] d, input logic [1:0] op);
    bit accepted = 0;
    bit rdy;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    for (int k = 0; k < 40 && !accepted; k++) begin
      rdy = in_ready;
      tick();
      if (rdy) accepted = 1;
    end
    in_valid = 1'b0;
    chk("in_accept", accepted, 1);
  endtask

  task automatic run_job(input logic [7:0] a[4], input logic [7:0] b[4], input logic [1:0] op,
                         input int stall, input bit gaps);
    logic [63:0] exp;
    int k;
    exp = ref_result(op, a, b);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        in_op    = 2'($urandom);
        tick();
      end
      send_elem(i < 4 ? a[i] : b[i-4], i == 0 ? op : 2'($urandom));
    end
    chk("alu_a_pack", alu_a, {a[3], a[2], a[1], a[0]});
    chk("alu_b_pack", alu_b, {b[3], b[2], b[1], b[0]});
    chk("alu_op", alu_op, op);
    chk("wait_busy", busy, 1);
    chk("wait_in_ready", in_ready, 0);
    k = 1;
    while (!out_valid && k < 60) begin
      tick();
      k++;
    end
    chk("latency", k, settle + 1);
    for (int j = 0; j < 4; j++) begin
      for (int s = 0; s < stall; s++) begin
        out_ready = 1'b0;
        chk("stall_data", out_data, exp[16*j +: 16]);
        chk("stall_idx", out_idx, j);
        chk("stall_in_ready", in_ready, 0);
        tick();
      end
      out_ready = 1'b1;
      chk("beat_valid", out_valid, 1);
      chk("beat_data", out_data, exp[16*j +: 16]);
      chk("beat_idx", out_idx, j);
      chk("beat_last", out_last, j == 3);
      chk("beat_err", out_err, op == 2'b11);
      tick();
      out_ready = 1'b0;
    end
    chk("done_valid", out_valid, 0);
    chk("done_in_ready", in_ready, 1);
    chk("done_busy", busy, 0);
    chk("done_idx", out_idx, 0);
    chk("hold_alu_a", alu_a, {a[3], a[2], a[1], a[0]});
  endtask

  task automatic rand_ops(output logic [7:0] a[4], output logic [7:0] b[4]);
    for (int i = 0; i < 4; i++) begin
      a[i] = 8'($urandom);
      b[i] = 8'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a[4];
    logic [7:0] b[4];
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_op = '0;
    sel = 0; settle = 2;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check_idle_reset();
    end
    sel = 0; settle = 2;
    #1;

    a = '{1, 2, 3, 4}; b = '{5, 6, 7, 8};
    chk("model_add", ref_result(OP_ADD, a, b), {16'd12, 16'd10, 16'd8, 16'd6});
    run_job(a, b, OP_ADD, 0, 0);
    chk("model_mult", ref_result(OP_MULT, a, b), {16'd50, 16'd43, 16'd22, 16'd19});
    run_job(a, b, OP_MULT, 0, 0);
    a = '{9, 8, 7, 6}; b = '{1, 2, 3, 4};
    run_job(a, b, OP_SUB, 5, 0);
    rand_ops(a, b);
    run_job(a, b, OP_RSVD, 1, 0);
    rand_ops(a, b);
    run_job(a, b, OP_ADD, 0, 0);

    // Abort after five elements; nothing from that job may appear.
    rand_ops(a, b);
    for (int i = 0; i < 5; i++) send_elem(i < 4 ? a[i] : b[0], OP_MULT);
    chk("partial_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_alu_a", alu_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_idle_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_beat", out_valid, 0);
      tick();
    end
    a = '{1, 2, 3, 4}; b = '{5, 6, 7, 8};
    run_job(a, b, OP_ADD, 0, 0);

    for (int n = 0; n < 6; n++) begin
      rand_ops(a, b);
      run_job(a, b, 2'($urandom), $urandom_range(0, 3), 0);
    end

    sel = 1; settle = 1;
    #1;
    a = '{1, 2, 3, 4}; b = '{5, 6, 7, 8};
    run_job(a, b, OP_ADD, 0, 1);
    rand_ops(a, b);
    run_job(a, b, OP_MULT, 0, 1);
    for (int n = 0; n < 6; n++) begin
      rand_ops(a, b);
      run_job(a, b, 2'($urandom), $urandom_range(0, 2), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
